// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Registers live in a 16-byte window at BASE_ADDR: TXDATA, STATUS, DIV, CTRL.
// Optional parity bit: define UART_TX_PARITY_EN to add a PARITY state
// (even parity, CTRL bit2 selects odd).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        sel_hit,
  output logic        uart_txd,
  output logic        irq
);

  // state  | meaning
  // IDLE   | line idle high, waiting for enable and a queued byte
  // START  | driving start bit (0)
  // DATA   | driving 8 data bits, LSB first
  // PARITY | driving parity bit (parity build only)
  // STOP   | driving stop bit (1); may chain straight into START
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;

  logic [15:0]   div_q, reload_q, timer_q;
  logic          enable_q, irq_en_q, overflow_q;
  state_t        state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [1:0]    offset;
  logic          wr_hit, push_req, push_ok, pop, bit_done, busy;
  logic [31:0]   status;
  logic          unused_bits;

`ifdef UART_TX_PARITY_EN
  logic          odd_q, parity_q;
`endif

  assign sel_hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = mem_addr[3:2];
  assign wr_hit      = mem_wen & sel_hit;
  assign push_req    = wr_hit & (offset == 2'd0);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign push_ok     = push_req & ~full;
  assign bit_done    = (timer_q == 16'd0);
  assign busy        = (state_q != IDLE);
  assign irq         = irq_en_q & empty & ~busy;
  assign unused_bits = ^{mem_addr[1:0], mem_data_i[31:16]};

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_data_i[7:0];
  end

  // FIFO pointers and occupancy; full is judged before any same-cycle pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Configuration registers and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= DIV_RESET;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      odd_q      <= 1'b0;
`endif
    end else begin
      if (wr_hit) begin
        case (offset)
          2'd1: if (mem_data_i[3]) overflow_q <= 1'b0;
          2'd2: div_q <= mem_data_i[15:0];
          2'd3: begin
            enable_q <= mem_data_i[0];
            irq_en_q <= mem_data_i[1];
`ifdef UART_TX_PARITY_EN
            odd_q    <= mem_data_i[2];
`endif
          end
          default: ;
        endcase
      end
      if (push_req && full) overflow_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state, pop request and line level
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    uart_txd = 1'b1;
    case (state_q)
      IDLE: begin
        if (enable_q && !empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        uart_txd = 1'b0;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        uart_txd = shift_q[0];
        if (bit_done && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        uart_txd = parity_q;
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (enable_q && !empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer (down-counter reloaded from the DIV value latched at pop) and shifter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= 8'h00;
      timer_q   <= 16'd0;
      reload_q  <= 16'd0;
      bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (pop) begin
      shift_q   <= fifo_mem[rd_ptr];
      timer_q   <= div_q;
      reload_q  <= div_q;
      bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= (^fifo_mem[rd_ptr]) ^ odd_q;
`endif
    end else if (busy) begin
      if (bit_done) begin
        timer_q <= reload_q;
        if (state_q == DATA) begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end else begin
        timer_q <= timer_q - 16'd1;
      end
    end
  end

  // Combinational read mux so the CPU can load status in the same cycle
  always_comb begin
    status           = 32'h0;
    status[0]        = full;
    status[1]        = empty;
    status[2]        = busy;
    status[3]        = overflow_q;
    status[8 +: CW]  = count;
    mem_data_o       = 32'h0;
    if (mem_ren && sel_hit) begin
      case (offset)
        2'd1: mem_data_o = status;
        2'd2: mem_data_o = {16'h0, div_q};
`ifdef UART_TX_PARITY_EN
        2'd3: mem_data_o = {29'h0, odd_q, irq_en_q, enable_q};
`else
        2'd3: mem_data_o = {30'h0, irq_en_q, enable_q};
`endif
        default: mem_data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-based line model checked every cycle,
// plus directed scenarios with hand-written expected waveforms.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX   = 32'hFFFF_0000;
  localparam logic [31:0] A_ST   = 32'hFFFF_0004;
  localparam logic [31:0] A_DIV  = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL = 32'hFFFF_000C;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_wen = 1'b0;
  logic        mem_ren = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_data_i = 32'h0;
  logic [31:0] mem_data_o;
  logic        sel_hit;
  logic        uart_txd;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;

  mmio_uart_tx dut (
    .clk(clk), .rst(rst), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .sel_hit(sel_hit), .uart_txd(uart_txd), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_fifo[$];
  bit           m_line[$];
  int           m_div = 867;
  bit           m_en = 0, m_irqen = 0, m_odd = 0, m_ovf = 0;

  task automatic push_frame(input byte unsigned b);
    bit fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    fb.push_back((^b) ^ m_odd);
`endif
    fb.push_back(1'b1);
    foreach (fb[k]) repeat (m_div + 1) m_line.push_back(fb[k]);
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_fifo.delete(); m_line.delete();
      m_div = 867; m_en = 0; m_irqen = 0; m_odd = 0; m_ovf = 0;
    end else begin
      automatic bit full_before = (m_fifo.size() == 8);
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_en && m_fifo.size() > 0) push_frame(m_fifo.pop_front());
      if (mem_wen && mem_addr[31:4] == A_TX[31:4]) begin
        case (mem_addr[3:2])
          2'd0: if (full_before) m_ovf = 1; else m_fifo.push_back(mem_data_i[7:0]);
          2'd1: if (mem_data_i[3]) m_ovf = 0;
          2'd2: m_div = int'(mem_data_i[15:0]);
          default: begin
            m_en = mem_data_i[0]; m_irqen = mem_data_i[1];
`ifdef UART_TX_PARITY_EN
            m_odd = mem_data_i[2];
`endif
          end
        endcase
      end
    end
  end

  // every-cycle comparison of line and interrupt against the model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("txd_model", {31'h0, uart_txd}, {31'h0, (m_line.size() > 0) ? m_line[0] : 1'b1});
      check("irq_model", {31'h0, irq},
            {31'h0, m_irqen && m_fifo.size() == 0 && m_line.size() == 0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    mem_wen = 0; mem_ren = 0; rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_wen = 1; mem_addr = a; mem_data_i = d;
    @(negedge clk);
    mem_wen = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_ren = 1; mem_addr = a;
    #1;
    d = mem_data_o;
    mem_ren = 0;
  endtask

  task automatic capture(input int n, output string wave, output string irqs, output int busy_n);
    logic [31:0] st;
    wave = ""; irqs = ""; busy_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (uart_txd) wave = {wave, "1"}; else wave = {wave, "0"};
      if (irq) irqs = {irqs, "1"}; else irqs = {irqs, "0"};
      bus_read(A_ST, st);
      if (st[2]) busy_n++;
    end
  endtask

  function automatic string expand(input string frame, input int per, input int total);
    string s = "";
    for (int i = 0; i < frame.len(); i++)
      for (int j = 0; j < per; j++) s = {s, frame.substr(i, i)};
    while (s.len() < total) s = {s, "1"};
    return s;
  endfunction

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] rd;
    string wave, irqs, f_a5, f_00, f_ff, f_03e, f_03o;
    int busy_n;
`ifdef UART_TX_PARITY_EN
    f_a5 = "01010010101"; f_00 = "00000000001"; f_ff = "01111111101";
    f_03e = "01100000001"; f_03o = "01100000011";
`else
    f_a5 = "0101001011"; f_00 = "0000000001"; f_ff = "0111111111";
    f_03e = ""; f_03o = "";
`endif

    // reset values and address decode
    do_reset();
    #1;
    bus_read(A_TX, rd);   check("rst_txdata", rd, 32'h0);
    bus_read(A_ST, rd);   check("rst_status", rd, 32'h0000_0002);
    bus_read(A_DIV, rd);  check("rst_div", rd, 32'd867);
    bus_read(A_CTRL, rd); check("rst_ctrl", rd, 32'h0);
    bus_read(32'hFFFF_000B, rd); check("div_low_bits_ignored", rd, 32'd867);
    check("rst_txd", {31'h0, uart_txd}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    mem_ren = 1; mem_addr = 32'hFFFF_0010; #1;
    check("outside_data", mem_data_o, 32'h0);
    check("outside_sel", {31'h0, sel_hit}, 32'h0);
    mem_addr = A_CTRL; #1;
    check("inside_sel", {31'h0, sel_hit}, 32'h1);
    mem_ren = 0; mem_addr = A_ST; #1;
    check("no_ren_data", mem_data_o, 32'h0);

    // single 0xA5 frame at DIV=3
    bus_write(A_DIV, 32'd3);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TX, 32'hA5);
    #1; bus_read(A_ST, rd); check("status_after_push", rd, 32'h0000_0100);
    capture(50, wave, irqs, busy_n);
    check_str("a5_wave", wave, expand(f_a5, 4, 50));
    check("a5_busy_cycles", busy_n, 4 * NBITS);

    // overflow with transmitter disabled
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + i);
    #1; bus_read(A_ST, rd); check("overflow_status", rd, 32'h0000_0809);
    bus_read(A_TX, rd);     check("txdata_reads_zero", rd, 32'h0);
    bus_write(A_ST, 32'h8);
    #1; bus_read(A_ST, rd); check("overflow_cleared", rd, 32'h0000_0801);

    // back-to-back frames at DIV=0 with irq
    do_reset();
    bus_write(A_DIV, 32'd0);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'hFF);
    bus_write(A_CTRL, 32'h3);
    capture(24, wave, irqs, busy_n);
    check_str("b2b_wave", wave, expand({f_00, f_ff}, 1, 24));
    check_str("b2b_irq", irqs, {rep("0", 2 * NBITS), rep("1", 24 - 2 * NBITS)});
    check("b2b_busy_cycles", busy_n, 2 * NBITS);

    // DIV change mid-frame only affects the next frame
    do_reset();
    bus_write(A_DIV, 32'd1);
    bus_write(A_TX, 32'h0F);
    bus_write(A_TX, 32'hF0);
    bus_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    bus_write(A_DIV, 32'd7);
    #1; bus_read(A_DIV, rd); check("div_readback", rd, 32'd7);
    capture(130, wave, irqs, busy_n);
    check("div_change_busy", busy_n, 10 * NBITS - 7);

    // reset asserted during DATA
    do_reset();
    bus_write(A_DIV, 32'd3);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TX, 32'h00);
    repeat (10) @(negedge clk);
    #1; check("txd_in_data", {31'h0, uart_txd}, 32'h0);
    #1; rst = 0;
    #1; check("txd_on_reset", {31'h0, uart_txd}, 32'h1);
    bus_read(A_ST, rd); check("status_on_reset", rd, 32'h0000_0002);
    @(negedge clk); rst = 1;
    #1; bus_read(A_CTRL, rd); check("ctrl_after_reset", rd, 32'h0);

    // CTRL bit2 and parity frames
    do_reset();
    bus_write(A_CTRL, 32'h6);
    #1; bus_read(A_CTRL, rd);
`ifdef UART_TX_PARITY_EN
    check("ctrl_bit2", rd, 32'h6);
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TX, 32'h03);
    capture(12, wave, irqs, busy_n);
    check_str("parity_even", wave, expand(f_03e, 1, 12));
    bus_write(A_CTRL, 32'h5);
    bus_write(A_TX, 32'h03);
    capture(12, wave, irqs, busy_n);
    check_str("parity_odd", wave, expand(f_03o, 1, 12));
`else
    check("ctrl_bit2", rd, 32'h2);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the CPU data-memory bus (mem_wen / mem_ren / mem_addr / mem_data_i / mem_data_o), sitting beside the data memory as a second responder. Stores written bytes in a small FIFO and serialises them as 8N1 frames on uart_txd at a programmable bit period. Read data is combinational so the single-cycle CPU can load status in the same cycle.

## Interface
- BASE_ADDR, 32'hFFFF_0000: 16-byte aligned base of the register window.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..64.
- DIV_RESET, 16'd867: reset value of DIV.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- mem_wen  in  1  bus write strobe.
- mem_ren  in  1  bus read strobe.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_data_i  in  32  write data.
- mem_data_o  out  32  read data; 0 when not selected.
- sel_hit  out  1  combinational: mem_addr[31:4] == BASE_ADDR[31:4].
- uart_txd  out  1  serial output, idle high.
- irq  out  1  level interrupt, TX drained.

## Operation
- Register offsets (mem_addr[3:2]): 0 TXDATA (W: push mem_data_i[7:0]; R: 0), 1 STATUS (R), 2 DIV (R/W, [15:0]), 3 CTRL (R/W, bit0 enable, bit1 irq_en).
- STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[14:8] FIFO count. Write STATUS with bit3=1 clears overflow; other bits read-only.
- Write accepted at posedge when mem_wen & sel_hit. Read: mem_data_o = selected register when mem_ren & sel_hit, else 32'b0.
- Push while full (count evaluated before any same-cycle pop): byte dropped, overflow set. Push into non-full FIFO always accepted, including same-cycle pop.
- FSM states IDLE, START, DATA, STOP. IDLE -> START when enable=1 and FIFO non-empty: pop head into shift register, latch DIV into bit timer reload. START drives 0, DATA drives 8 bits LSB first, STOP drives 1; each bit lasts DIV+1 cycles. STOP -> START directly if enable and FIFO non-empty, else IDLE.
- DIV writes mid-frame affect the next frame only. Clearing enable mid-frame finishes the current frame, then stays IDLE.
- irq = irq_en & empty & ~busy.
- Reset: FIFO empty, overflow 0, DIV = DIV_RESET, CTRL = 0, FSM IDLE, uart_txd = 1, irq = 0, mem_data_o = 0 (combinational).

## Timing
- Pop at posedge k (IDLE, enabled, non-empty); uart_txd low from edge k for DIV+1 cycles.
- Frame length 10*(DIV+1) cycles; busy high for exactly that span when one byte is queued.
- Back-to-back frames: no idle cycle between STOP and next START.
- Write TXDATA at edge k with FSM IDLE and enable=1: pop at edge k+1; STATUS.empty visible 0 after edge k.
- DIV=0: one cycle per bit, 10-cycle frame.
- FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- rst asserted mid-frame: uart_txd returns to 1 immediately, FIFO contents discarded.

## Configuration
- UART_TX_PARITY_EN defined: FSM adds state PARITY between DATA and STOP driving even parity (XOR of 8 data bits); frame 11*(DIV+1) cycles; CTRL bit2 selects odd parity when 1.
- Undefined: no PARITY state, CTRL bit2 reads 0 and ignores writes, 10-bit frame.

## Test plan
- Reset, read all four offsets -> TXDATA 0, STATUS 0x0000_0002, DIV 867, CTRL 0; uart_txd 1; read outside window -> 0, sel_hit 0.
- DIV=3, CTRL=1, write 0xA5 -> txd 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop 1; busy high exactly 40 cycles.
- CTRL=0, write 9 bytes (FIFO_DEPTH 8) -> STATUS full=1, count=8, overflow=1; write STATUS 0x8 -> overflow 0.
- DIV=0, queue 0x00 and 0xFF, enable -> 20 contiguous cycles, no idle gap between frames; irq (irq_en=1) rises after last stop bit.
- Write DIV=7 mid-frame with DIV=1 -> current frame keeps 2-cycle bits, next frame uses 8-cycle bits.
- Assert rst during DATA -> uart_txd 1 and STATUS empty immediately; with UART_TX_PARITY_EN, 0x03 frame shows parity bit 0 (even) then stop.
